// File: rtl/rf_wport_sched_pkg.sv
// Shared sizing and FSM encoding for the register-file write-port scheduler.
package rf_wport_sched_pkg;

   localparam int RF_REG_W      = 3;
   localparam int RF_DATA_W     = 16;
   localparam int RF_REG        = 8;
   localparam int RF_STARVE_MAX = 4;

   typedef enum logic {
      ARB   = 1'b0,
      FORCE = 1'b1
   } wsched_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Outstanding-LLU-result scoreboard and decode hazard detection for the register file.
module rf_scoreboard
   import rf_wport_sched_pkg::*;
#(
   parameter int REG_W = RF_REG_W,
   parameter int REG   = RF_REG
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iss_valid,
   input  logic [REG_W-1:0] iss_dst,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_dst,
   input  logic [REG_W-1:0] dec_src1,
   input  logic [REG_W-1:0] dec_src2,
   input  logic [REG_W-1:0] dec_dst,
   input  logic             hold,
   output logic             dec_stall,
   output logic [REG-1:0]   busy
);

   logic [REG-1:0] busy_q;
   logic [REG-1:0] busy_vis;
   logic [REG-1:0] busy_d;
   logic           hazard;
   logic           set_en;

   // A result retiring this cycle is already readable (negedge write), so it no longer blocks decode.
   always_comb begin
      busy_vis = busy_q;
      if (clr_en) busy_vis[clr_dst] = 1'b0;
   end

   assign hazard = ((dec_src1 != '0) && busy_vis[dec_src1]) ||
                   ((dec_src2 != '0) && busy_vis[dec_src2]) ||
                   ((dec_dst  != '0) && busy_vis[dec_dst]);

   assign dec_stall = rst_n && (hazard || hold);
   assign set_en    = iss_valid && !dec_stall && (iss_dst != '0);

   // Set is applied after clear so a same-register collision leaves the bit set.
   always_comb begin
      busy_d = busy_vis;
      if (set_en) busy_d[iss_dst] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/rf_wport_sched.sv
// Shares the register-file write port between pipeline writeback and the long-latency unit.
//   state | meaning
//   ARB   | WB has priority; a denied LLU result ages toward a forced grant
//   FORCE | one cycle: LLU owns the port, WB and decode are held
module rf_wport_sched
   import rf_wport_sched_pkg::*;
#(
   parameter int REG_W      = RF_REG_W,
   parameter int DATA_W     = RF_DATA_W,
   parameter int REG        = RF_REG,
   parameter int STARVE_MAX = RF_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_we,
   input  logic [REG_W-1:0]  wb_dst,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_hold,
   input  logic              llu_valid,
   input  logic [REG_W-1:0]  llu_dst,
   input  logic [DATA_W-1:0] llu_data,
   output logic              llu_ready,
   input  logic              iss_valid,
   input  logic [REG_W-1:0]  iss_dst,
   input  logic [REG_W-1:0]  dec_src1,
   input  logic [REG_W-1:0]  dec_src2,
   input  logic [REG_W-1:0]  dec_dst,
   output logic              dec_stall,
   output logic [REG_W-1:0]  rf_a3,
   output logic [DATA_W-1:0] rf_wd3,
   output logic              rf_we3,
   output logic [REG-1:0]    busy
);

   localparam int AGE_W = $clog2(STARVE_MAX + 1);

   wsched_state_t    state_q, state_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic             wb_live;

   assign wb_live = wb_we && (wb_dst != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
      end
   end

   // Only a non-null LLU result denied by a live WB ages; any grant or idle cycle clears it.
   always_comb begin
      state_d = ARB;
      age_d   = '0;
      if ((state_q == ARB) && wb_live && llu_valid && (llu_dst != '0)) begin
         age_d = (age_q == AGE_W'(STARVE_MAX)) ? age_q : age_q + 1'b1;
         if (age_d == AGE_W'(STARVE_MAX)) state_d = FORCE;
      end
   end

   always_comb begin
      wb_hold   = 1'b0;
      llu_ready = 1'b0;
      rf_we3    = 1'b0;
      rf_a3     = '0;
      rf_wd3    = '0;
      if (rst_n) begin
         if (state_q == FORCE) begin
            wb_hold   = 1'b1;
            llu_ready = llu_valid;
            rf_we3    = llu_valid && (llu_dst != '0);
            rf_a3     = llu_dst;
            rf_wd3    = llu_data;
         end else if (wb_live) begin
            rf_we3    = 1'b1;
            rf_a3     = wb_dst;
            rf_wd3    = wb_data;
            llu_ready = llu_valid && (llu_dst == '0);
         end else if (llu_valid) begin
            llu_ready = 1'b1;
            rf_we3    = (llu_dst != '0);
            rf_a3     = llu_dst;
            rf_wd3    = llu_data;
         end
      end
   end

   rf_scoreboard #(
      .REG_W (REG_W),
      .REG   (REG)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_dst   (iss_dst),
      .clr_en    (llu_ready),
      .clr_dst   (llu_dst),
      .dec_src1  (dec_src1),
      .dec_src2  (dec_src2),
      .dec_dst   (dec_dst),
      .hold      (wb_hold),
      .dec_stall (dec_stall),
      .busy      (busy)
   );

endmodule

// File: tb/tb_rf_wport_sched.sv
// Scoreboard bench for rf_wport_sched: directed scenarios followed by random traffic.
module tb_rf_wport_sched;

   localparam int RW = 3;
   localparam int DW = 16;
   localparam int NR = 8;
   localparam int SM = 4;

   logic          clk, rst_n;
   logic          wb_we, llu_valid, iss_valid;
   logic [RW-1:0] wb_dst, llu_dst, iss_dst, dec_src1, dec_src2, dec_dst;
   logic [DW-1:0] wb_data, llu_data;
   logic          wb_hold, llu_ready, dec_stall, rf_we3;
   logic [RW-1:0] rf_a3;
   logic [DW-1:0] rf_wd3;
   logic [NR-1:0] busy;

   rf_wport_sched #(.REG_W(RW), .DATA_W(DW), .REG(NR), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data), .wb_hold(wb_hold),
      .llu_valid(llu_valid), .llu_dst(llu_dst), .llu_data(llu_data), .llu_ready(llu_ready),
      .iss_valid(iss_valid), .iss_dst(iss_dst),
      .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_dst(dec_dst), .dec_stall(dec_stall),
      .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3), .busy(busy)
   );

   typedef struct {
      logic [RW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   // Reference model state: registers awaiting an LLU result, cycles the pending result has waited.
   bit  m_busy[NR];
   int  m_wait  = 0;
   bit  m_force = 0;
   bit  m_rdy   = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_we = 0; wb_dst = 0; wb_data = 0;
      llu_valid = 0; llu_dst = 0; llu_data = 0;
      iss_valid = 0; iss_dst = 0;
      dec_src1 = 0; dec_src2 = 0; dec_dst = 0;
   endtask

   function automatic logic [RW-1:0] pick_llu_reg();
      int r;
      r = $urandom_range(3, 7);
      return (r == 3) ? RW'(0) : RW'(r);
   endfunction

   function automatic logic [NR-1:0] model_busy_vec();
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // Reference model: evaluated mid-cycle while inputs are stable.
   initial begin
      bit            e_rdy, e_we, e_hold, e_stall, wb_nn;
      logic [RW-1:0] e_a;
      logic [DW-1:0] e_d;
      bit            vis[NR];
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 0;
            m_wait = 0; m_force = 0; m_rdy = 0;
         end else begin
            wb_nn  = wb_we && (wb_dst != 0);
            e_hold = m_force;
            if (m_force) begin
               e_rdy = llu_valid; e_we = llu_valid && (llu_dst != 0); e_a = llu_dst; e_d = llu_data;
            end else if (wb_nn) begin
               e_we = 1; e_a = wb_dst; e_d = wb_data; e_rdy = llu_valid && (llu_dst == 0);
            end else begin
               e_rdy = llu_valid; e_we = llu_valid && (llu_dst != 0); e_a = llu_dst; e_d = llu_data;
            end
            vis = m_busy;
            if (e_rdy) vis[llu_dst] = 0;
            e_stall = e_hold || (dec_src1 != 0 && vis[dec_src1]) ||
                      (dec_src2 != 0 && vis[dec_src2]) || (dec_dst != 0 && vis[dec_dst]);

            chk("busy", busy, model_busy_vec());
            chk("llu_ready", llu_ready, e_rdy);
            chk("wb_hold", wb_hold, e_hold);
            chk("dec_stall", dec_stall, e_stall);
            chk("rf_we3", rf_we3, e_we);
            if (e_we) exp_q.push_back('{a: e_a, d: e_d});

            if (wb_nn && m_busy[wb_dst]) begin
               n_errors++;
               $display("FAIL protocol_wb_to_busy: reg %0d busy %0d required 0", wb_dst, m_busy[wb_dst]);
            end
            if (e_rdy && iss_valid && !e_stall && iss_dst != 0 && iss_dst == llu_dst) begin
               n_errors++;
               $display("FAIL protocol_issue_on_retire: reg %0d set and cleared together", iss_dst);
            end

            m_busy = vis;
            if (iss_valid && !e_stall && iss_dst != 0) m_busy[iss_dst] = 1;
            if (e_rdy || !llu_valid) m_wait = 0;
            else                     m_wait++;
            m_force = !m_force && (m_wait >= SM);
            m_rdy   = e_rdy;
         end
      end
   end

   // Write-port monitor: every DUT write must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && rf_we3 === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_write: a3 %0d wd3 %0h with nothing predicted", rf_a3, rf_wd3);
            end else begin
               e = exp_q.pop_front();
               chk("rf_a3", rf_a3, e.a);
               chk("rf_wd3", rf_wd3, e.d);
            end
         end
      end
   end

   initial begin
      // Reset held with every input active.
      rst_n = 0;
      wb_we = 1; wb_dst = 3; wb_data = 16'h1234;
      llu_valid = 1; llu_dst = 5; llu_data = 16'h5555;
      iss_valid = 1; iss_dst = 4; dec_src1 = 4; dec_src2 = 5; dec_dst = 4;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_we3", rf_we3, 0);
      chk("rst_llu_ready", llu_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", dec_stall, 0);
      chk("rst_hold", wb_hold, 0);

      cyc(); idle(); rst_n = 1;
      wb_we = 1; wb_dst = 3; wb_data = 16'h00AA;
      #1;
      chk("first_wb_we3", rf_we3, 1);
      chk("first_wb_a3", rf_a3, 3);
      chk("first_wb_wd3", rf_wd3, 16'h00AA);

      // WB beats LLU, LLU goes next cycle.
      cyc(); idle();
      wb_we = 1; wb_dst = 2; wb_data = 16'h0202;
      llu_valid = 1; llu_dst = 5; llu_data = 16'h0505;
      #1;
      chk("conflict_a3_wb", rf_a3, 2);
      chk("conflict_ready0", llu_ready, 0);
      cyc(); wb_we = 0; #1;
      chk("conflict_ready1", llu_ready, 1);
      chk("conflict_a3_llu", rf_a3, 5);
      cyc(); idle();

      // Starvation: four denied cycles, then a forced grant while WB is frozen.
      for (int i = 0; i < SM; i++) begin
         cyc();
         wb_we = 1; wb_dst = 1; wb_data = DW'(16'h0100 + i);
         llu_valid = 1; llu_dst = 6; llu_data = 16'h0606;
         #1;
         chk("starve_denied", llu_ready, 0);
      end
      cyc(); wb_data = 16'h01FF; #1;
      chk("force_hold", wb_hold, 1);
      chk("force_ready", llu_ready, 1);
      chk("force_stall", dec_stall, 1);
      chk("force_a3", rf_a3, 6);
      cyc(); llu_valid = 0; #1;
      chk("held_wb_a3", rf_a3, 1);
      chk("held_wb_wd3", rf_wd3, 16'h01FF);
      chk("held_wb_nohold", wb_hold, 0);
      cyc(); idle();

      // RAW against an outstanding LLU result, released in the retiring cycle.
      cyc(); iss_valid = 1; iss_dst = 4; dec_dst = 4;
      cyc(); idle(); dec_src1 = 4; dec_dst = 7; #1;
      chk("raw_busy4", busy[4], 1);
      chk("raw_stall", dec_stall, 1);
      cyc(); #1;
      chk("raw_stall_hold", dec_stall, 1);
      cyc(); llu_valid = 1; llu_dst = 4; llu_data = 16'h0404; #1;
      chk("raw_retire_ready", llu_ready, 1);
      chk("raw_retire_nostall", dec_stall, 0);
      cyc(); llu_valid = 0; #1;
      chk("raw_busy4_clear", busy[4], 0);
      cyc(); idle();

      // r0: null LLU result accepted alongside a WB; issue to r0 sets nothing.
      cyc(); wb_we = 1; wb_dst = 3; wb_data = 16'h0033;
      llu_valid = 1; llu_dst = 0; llu_data = 16'hDEAD; #1;
      chk("r0_ready", llu_ready, 1);
      chk("r0_we3", rf_we3, 1);
      chk("r0_a3", rf_a3, 3);
      cyc(); idle(); iss_valid = 1; iss_dst = 0; #1;
      chk("r0_src_nostall", dec_stall, 0);
      cyc(); idle(); #1;
      chk("r0_busy_unchanged", busy, 0);

      // Async reset in FORCE with registers 4 and 5 outstanding.
      cyc(); iss_valid = 1; iss_dst = 4; dec_dst = 4;
      cyc(); iss_dst = 5; dec_dst = 5;
      for (int i = 0; i < SM; i++) begin
         cyc(); idle();
         wb_we = 1; wb_dst = 1; wb_data = DW'(16'h0A00 + i);
         llu_valid = 1; llu_dst = 6; llu_data = 16'h0066;
      end
      cyc(); #1;
      chk("pre_arst_hold", wb_hold, 1);
      chk("pre_arst_busy", busy, 8'h30);
      #1; rst_n = 0; #1;
      chk("arst_busy", busy, 0);
      chk("arst_hold", wb_hold, 0);
      chk("arst_ready", llu_ready, 0);
      chk("arst_we3", rf_we3, 0);
      chk("arst_stall", dec_stall, 0);
      chk("arst_a3", rf_a3, 0);
      chk("arst_wd3", rf_wd3, 0);
      cyc(); idle(); rst_n = 1;
      cyc(); #1;
      chk("post_arst_hold", wb_hold, 0);

      // Random traffic: WB uses r0-r3, the LLU and issue use r0 and r4-r7.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (!m_force) begin
            wb_we   = ($urandom_range(0, 3) != 0);
            wb_dst  = RW'($urandom_range(0, 3));
            wb_data = DW'($urandom);
         end
         if (!llu_valid || m_rdy) begin
            llu_valid = ($urandom_range(0, 2) == 0);
            llu_dst   = pick_llu_reg();
            llu_data  = DW'($urandom);
         end
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_dst   = pick_llu_reg();
         if (llu_valid && iss_dst == llu_dst) iss_dst = 0;
         dec_dst   = iss_valid ? iss_dst : pick_llu_reg();
         dec_src1  = RW'($urandom_range(0, 7));
         dec_src2  = RW'($urandom_range(0, 7));
      end

      cyc(); idle();
      repeat (4) cyc();
      chk("write_queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_wport_sched.md
Name: rf_wport_sched

Overview:
- Write-port scheduler and scoreboard for the pipelined CPU register file.
- Shares the single register-file write port (a3/wd3/we3) between two sources:
  - the in-order pipeline writeback (WB);
  - the long-latency unit (LLU: multi-cycle mul/div/load) result port.
- Tracks registers with an LLU result still outstanding and stalls decode on RAW/WAW hazards against them.
- Sits between the WB stage, the LLU and the register file.

Parameters:
- REG_W, `REG_W, register index width
- DATA_W, `DATA_W, data width
- REG, `REG, number of architectural registers
- STARVE_MAX, 4, maximum cycles an LLU result may wait before it is force-granted (>=1)

Ports:
- clk  in  1  clock; register file writes on negedge, this block updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- wb_we  in  1  pipeline writeback request
- wb_dst  in  REG_W  WB destination
- wb_data  in  DATA_W  WB data
- wb_hold  out  1  asks pipeline to freeze WB (and everything behind it) this cycle
- llu_valid  in  1  LLU result pending
- llu_dst  in  REG_W  LLU destination
- llu_data  in  DATA_W  LLU data
- llu_ready  out  1  LLU result accepted this cycle
- iss_valid  in  1  decode issues an op to the LLU this cycle
- iss_dst  in  REG_W  destination of the issued LLU op
- dec_src1, dec_src2, dec_dst  in  REG_W  register fields of the instruction in decode
- dec_stall  out  1  hazard stall to decode
- rf_a3  out  REG_W  to rfile a3
- rf_wd3  out  DATA_W  to rfile wd3
- rf_we3  out  1  to rfile we3
- busy  out  REG  scoreboard vector, debug/verification

Behaviour:
- Reset (rst_n low, async):
  - busy = 0, age = 0, state = ARB.
  - rf_we3, llu_ready, wb_hold, dec_stall all forced 0; rf_a3/rf_wd3 = 0.
- r0 is hardwired zero:
  - WB or LLU requests with dst 0 are "null".
  - A null WB consumes no port.
  - A null LLU result is accepted immediately (llu_ready=1, rf_we3 unaffected).
  - iss_dst 0 never sets busy.
- Port mux is combinational, zero latency; the write lands at the following negedge.
- State ARB:
  - If a non-null WB is present: WB owns the port and llu_ready=0.
    - If llu_valid, age increments (saturating at STARVE_MAX).
  - Otherwise a valid LLU result is granted: llu_ready=1, rf_* = LLU fields.
  - age clears whenever the LLU is granted or llu_valid=0.
  - age == STARVE_MAX with llu_valid still pending -> state FORCE.
- State FORCE (exactly one cycle):
  - LLU granted unconditionally; wb_hold=1.
  - The pipeline must keep WB fields stable; WB writes next cycle.
  - age <= 0, return to ARB.
- Scoreboard, updated on posedge:
  - busy[iss_dst] set when iss_valid && !dec_stall.
  - busy[llu_dst] cleared when llu_ready.
  - Different registers in the same cycle: both updates apply.
  - Same register: set wins. This can only arise from an illegal issue; it is flagged by a bench assertion.
- Hazard (combinational):
  - dec_stall = (busy'[dec_src1] | busy'[dec_src2] | busy'[dec_dst]) for non-zero fields.
  - busy' is busy with the bit for llu_dst cleared when llu_ready is high this cycle. This is legal because the negedge write makes the value readable in the same cycle.
  - dec_stall is also asserted whenever wb_hold is asserted.
- iss_valid while dec_stall=1 is ignored.
- WB to a register with busy=1 is a protocol violation; the bench asserts it never occurs.
- llu_valid may drop only after llu_ready; llu_dst/llu_data stay stable while valid.
- Reset mid-operation: any in-flight grant is dropped and the scoreboard is cleared. The LLU must also be reset by the same rst_n.

Decomposition:
- Shared def.h gains `STARVE_MAX and the state encodings ARB=1'b0, FORCE=1'b1. `REG_W, `DATA_W and `REG are reused from there.
- One sub-module, rf_scoreboard: the busy vector, set/clear logic and the hazard compare. Arbitration, the age counter and the FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0 with all inputs active -> rf_we3=0, llu_ready=0, busy=0. Release; the first WB (dst=3, data=16'h00AA) drives rf_we3=1, rf_a3=3 in the same cycle.
- Conflict: WB dst=2 and LLU dst=5 valid together -> WB written and llu_ready=0. Next cycle with WB idle -> llu_ready=1, rf_a3=5.
- Starvation: continuous non-null WB with llu_valid held, STARVE_MAX=4 -> after 4 denied cycles, FORCE cycle has wb_hold=1, llu_ready=1, dec_stall=1. The held WB is written the following cycle.
- RAW: issue LLU op dst=4, then decode src1=4 -> dec_stall=1 until the cycle llu_ready with llu_dst=4; dec_stall=0 in that same cycle. busy[4]=0 after the posedge.
- r0: LLU result dst=0 -> llu_ready=1 with rf_we3 still reflecting the concurrent WB. iss_dst=0 -> busy unchanged, and src1=0 never stalls.
- Async reset with busy=8'h30 and FSM in FORCE -> busy=0, ARB and all outputs 0 immediately, without waiting for a clock edge.
